// File: rtl/wdog_rst_gen.sv
// wdog_rst_gen: watchdog reset generator.
// Counts cycles while armed. If no kick arrives within TIMEOUT cycles, it drives
// rst_req_n low for RST_PULSE cycles and sets a sticky bite_flag. The block runs
// on the power-on reset domain, so bite_flag survives the reset it requests.
// Optional feature macro: WDOG_WARN_EN adds an early-warning output 'warn' that
// rises when the count reaches TIMEOUT/2.
module wdog_rst_gen #(
  parameter int TIMEOUT   = 1000000,
  parameter int CNT_W     = 20,
  parameter int RST_PULSE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic kick,
  input  logic clr_flag,
  output logic rst_req_n,
  output logic bite_flag
`ifdef WDOG_WARN_EN
  ,
  output logic warn
`endif
);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_RUNNING  = 2'd1,
    S_BITE     = 2'd2
  } state_t;

  // Integer-domain constants, sliced to the register widths they compare against.
  localparam int unsigned LAST_I  = TIMEOUT - 1;
  localparam int unsigned HALF_I  = TIMEOUT / 2;
  localparam int unsigned PLAST_I = RST_PULSE - 1;

  localparam logic [CNT_W-1:0] C_LAST  = LAST_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] C_ZERO  = '0;
  localparam logic [CNT_W-1:0] C_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       C_PLAST = PLAST_I[7:0];
  localparam logic [7:0]       C_PONE  = 8'd1;

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [7:0]       r_pcnt;
  logic [7:0]       w_pcnt_nx;
  logic             r_req_n;
  logic             w_req_nx;
  logic             r_flag;
  logic             w_flag_nx;
`ifdef WDOG_WARN_EN
  localparam logic [CNT_W-1:0] C_HALF = HALF_I[CNT_W-1:0];
  logic             r_warn;
  logic             w_warn_nx;
`endif

  assign w_cnt_inc = r_cnt + C_ONE;

  // Next-state and next-output logic; every registered output is decided here.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_pcnt_nx  = r_pcnt;
    w_req_nx   = r_req_n;
    w_flag_nx  = r_flag;
`ifdef WDOG_WARN_EN
    w_warn_nx  = r_warn;
`endif
    // Clear first so that a bite in the same cycle overrides it.
    if (clr_flag) w_flag_nx = 1'b0;
    case (r_state)
      S_DISARMED: begin
        w_cnt_nx = C_ZERO;
        if (en) w_state_nx = S_RUNNING;
      end
      S_RUNNING: begin
        if (!en) begin
          w_state_nx = S_DISARMED;
          w_cnt_nx   = C_ZERO;
`ifdef WDOG_WARN_EN
          w_warn_nx  = 1'b0;
`endif
        end else if (kick) begin
          w_cnt_nx   = C_ZERO;
`ifdef WDOG_WARN_EN
          w_warn_nx  = 1'b0;
`endif
        end else if (r_cnt == C_LAST) begin
          w_state_nx = S_BITE;
          w_cnt_nx   = C_ZERO;
          w_pcnt_nx  = 8'd0;
          w_req_nx   = 1'b0;
          w_flag_nx  = 1'b1;
`ifdef WDOG_WARN_EN
          w_warn_nx  = 1'b0;
`endif
        end else begin
          w_cnt_nx   = w_cnt_inc;
`ifdef WDOG_WARN_EN
          if (w_cnt_inc == C_HALF) w_warn_nx = 1'b1;
`endif
        end
      end
      S_BITE: begin
        // en and kick are deliberately ignored: a started pulse always completes.
        if (r_pcnt == C_PLAST) begin
          w_state_nx = S_DISARMED;
          w_pcnt_nx  = 8'd0;
          w_req_nx   = 1'b1;
        end else begin
          w_pcnt_nx  = r_pcnt + C_PONE;
        end
      end
      default: begin
        w_state_nx = S_DISARMED;
        w_cnt_nx   = C_ZERO;
        w_pcnt_nx  = 8'd0;
        w_req_nx   = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_DISARMED;
      r_cnt   <= C_ZERO;
      r_pcnt  <= 8'd0;
      r_req_n <= 1'b1;
      r_flag  <= 1'b0;
`ifdef WDOG_WARN_EN
      r_warn  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_pcnt  <= w_pcnt_nx;
      r_req_n <= w_req_nx;
      r_flag  <= w_flag_nx;
`ifdef WDOG_WARN_EN
      r_warn  <= w_warn_nx;
`endif
    end
  end

  assign rst_req_n = r_req_n;
  assign bite_flag = r_flag;
`ifdef WDOG_WARN_EN
  assign warn      = r_warn;
`endif

endmodule
